// File: rtl/dragon_body.sv
// Dragon body: tile-history shift buffer with length control, a body/player
// collision flag and a sticky dead flag.
module dragon_body #(
  parameter int unsigned MAX_LEN   = 8,
  parameter int unsigned INIT_LEN  = 3,
  parameter logic [7:0]  RESET_LOC = 8'h77,
  parameter logic [1:0]  RESET_DIR = 2'b00
) (
  input  logic       frame_clk,
  input  logic       rst,
  input  logic       move_valid,
  input  logic [7:0] head_location,
  input  logic [1:0] head_direction,
  input  logic       grow,
  input  logic       shrink,
  input  logic [7:0] player_location,
  input  logic [3:0] seg_index,
  output logic [7:0] seg_location,
  output logic [1:0] seg_direction,
  output logic       seg_active,
  output logic [3:0] body_length,
  output logic       hit_player,
  output logic       dragon_dead
);

  localparam int unsigned LOC_W = 8;
  localparam int unsigned DIR_W = 2;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned IDX_W = 4;

  typedef struct packed {
    logic [LOC_W-1:0] loc;
    logic [DIR_W-1:0] dir;
  } seg_t;

  seg_t             slots [MAX_LEN];
  logic [LEN_W-1:0] next_len;
  logic             next_dead;
  logic             match;

  // Length update: grow/shrink cancel each other, saturate at MAX_LEN, floor at 0.
  always_comb begin
    next_len  = body_length;
    next_dead = dragon_dead;
    if (!dragon_dead) begin
      if (grow && !shrink && (body_length < LEN_W'(MAX_LEN))) begin
        next_len = body_length + LEN_W'(1);
      end else if (shrink && !grow && (body_length != '0)) begin
        next_len = body_length - LEN_W'(1);
      end
      next_dead = (next_len == '0);
    end
  end

  // Collision against active segments only, from pre-edge slots and length.
  always_comb begin
    match = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < body_length) && (slots[i].loc == player_location)) begin
        match = 1'b1;
      end
    end
  end

  always_ff @(posedge frame_clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        slots[i] <= '{loc: RESET_LOC, dir: RESET_DIR};
      end
      body_length <= LEN_W'(INIT_LEN);
      hit_player  <= 1'b0;
      dragon_dead <= 1'b0;
    end else begin
      if (move_valid && !dragon_dead) begin
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
          slots[i] <= slots[i-1];
        end
        slots[0] <= '{loc: head_location, dir: head_direction};
      end
      body_length <= next_len;
      dragon_dead <= next_dead;
      // A dead dragon never reports a hit, including on the edge it dies.
      hit_player  <= match && !next_dead;
    end
  end

  // Renderer read port; out-of-range indices read as zero.
  always_comb begin
    seg_location  = '0;
    seg_direction = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (seg_index == IDX_W'(i)) begin
        seg_location  = slots[i].loc;
        seg_direction = slots[i].dir;
      end
    end
    seg_active = (seg_index < body_length);
  end

endmodule

// File: tb/tb_dragon_body.sv
// Bench for dragon_body: per-cycle comparison against a behavioural model plus
// directed literal expectations.
module tb_dragon_body;

  localparam int MAXL = 8;

  logic       frame_clk = 1'b0;
  logic       rst;
  logic       move_valid;
  logic [7:0] head_location;
  logic [1:0] head_direction;
  logic       grow;
  logic       shrink;
  logic [7:0] player_location;
  logic [3:0] seg_index;
  logic [7:0] seg_location;
  logic [1:0] seg_direction;
  logic       seg_active;
  logic [3:0] body_length;
  logic       hit_player;
  logic       dragon_dead;

  int checks   = 0;
  int failures = 0;

  // Model state
  int m_loc [MAXL];
  int m_dir [MAXL];
  int m_len;
  int m_dead;
  int m_hit;

  dragon_body dut (
    .frame_clk      (frame_clk),
    .rst            (rst),
    .move_valid     (move_valid),
    .head_location  (head_location),
    .head_direction (head_direction),
    .grow           (grow),
    .shrink         (shrink),
    .player_location(player_location),
    .seg_index      (seg_index),
    .seg_location   (seg_location),
    .seg_direction  (seg_direction),
    .seg_active     (seg_active),
    .body_length    (body_length),
    .hit_player     (hit_player),
    .dragon_dead    (dragon_dead)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: everything computed from pre-edge state first.
  always @(posedge frame_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAXL; i++) begin
        m_loc[i] = 'h77;
        m_dir[i] = 0;
      end
      m_len  = 3;
      m_dead = 0;
      m_hit  = 0;
    end else if (m_dead != 0) begin
      m_hit = 0;
    end else begin
      int hit;
      int len;
      hit = 0;
      for (int i = 0; i < m_len; i++) if (m_loc[i] == int'(player_location)) hit = 1;
      len = m_len;
      if (grow && !shrink) len = (m_len + 1 > MAXL) ? MAXL : m_len + 1;
      if (shrink && !grow) len = (m_len == 0) ? 0 : m_len - 1;
      if (move_valid) begin
        for (int i = MAXL - 1; i > 0; i--) begin
          m_loc[i] = m_loc[i-1];
          m_dir[i] = m_dir[i-1];
        end
        m_loc[0] = int'(head_location);
        m_dir[0] = int'(head_direction);
      end
      m_len  = len;
      m_dead = (len == 0) ? 1 : 0;
      m_hit  = (m_dead != 0) ? 0 : hit;
    end
  end

  // Per-cycle compare on the falling edge, outside reset.
  always @(negedge frame_clk) begin
    if (!rst) begin
      int idx;
      idx = int'(seg_index);
      check("body_length", int'(body_length), m_len);
      check("dragon_dead", int'(dragon_dead), m_dead);
      check("hit_player", int'(hit_player), m_hit);
      check("seg_location", int'(seg_location), (idx < MAXL) ? m_loc[idx] : 0);
      check("seg_direction", int'(seg_direction), (idx < MAXL) ? m_dir[idx] : 0);
      check("seg_active", int'(seg_active), (idx < m_len) ? 1 : 0);
    end
  end

  // One frame: drive inputs just after a rising edge, hold across the next one.
  task automatic step(input logic mv, input logic [7:0] loc, input logic [1:0] dir,
                      input logic g, input logic s);
    move_valid     = mv;
    head_location  = loc;
    head_direction = dir;
    grow           = g;
    shrink         = s;
    @(posedge frame_clk);
    #1;
    move_valid = 1'b0;
    grow       = 1'b0;
    shrink     = 1'b0;
    seg_index  = seg_index + 4'd1;
  endtask

  task automatic read_seg(input int idx, input int exp_loc, input int exp_dir, input int exp_act);
    seg_index = 4'(idx);
    #1;
    check($sformatf("lit_seg%0d_loc", idx), int'(seg_location), exp_loc);
    check($sformatf("lit_seg%0d_dir", idx), int'(seg_direction), exp_dir);
    check($sformatf("lit_seg%0d_act", idx), int'(seg_active), exp_act);
  endtask

  initial begin
    rst             = 1'b1;
    move_valid      = 1'b0;
    head_location   = 8'h00;
    head_direction  = 2'b00;
    grow            = 1'b0;
    shrink          = 1'b0;
    player_location = 8'h00;
    seg_index       = 4'd0;
    #12;
    // Reset state
    check("lit_reset_len", int'(body_length), 3);
    check("lit_reset_hit", int'(hit_player), 0);
    check("lit_reset_dead", int'(dragon_dead), 0);
    for (int i = 0; i < MAXL; i++) read_seg(i, 'h77, 0, (i < 3) ? 1 : 0);
    read_seg(8, 0, 0, 0);
    @(posedge frame_clk);
    #1;
    rst = 1'b0;

    // Head trail
    step(1'b1, 8'h45, 2'd1, 1'b0, 1'b0);
    step(1'b1, 8'h46, 2'd2, 1'b0, 1'b0);
    step(1'b1, 8'h47, 2'd3, 1'b0, 1'b0);
    read_seg(0, 'h47, 3, 1);
    read_seg(1, 'h46, 2, 1);
    read_seg(2, 'h45, 1, 1);
    read_seg(3, 'h77, 0, 0);

    // Collision on an active segment
    player_location = 8'h46;
    step(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    check("lit_hit_active", int'(hit_player), 1);
    step(1'b1, 8'h48, 2'd0, 1'b0, 1'b0);
    step(1'b1, 8'h49, 2'd0, 1'b0, 1'b0);
    step(1'b1, 8'h4A, 2'd1, 1'b0, 1'b0);
    // 45 now only in inactive slot 5
    player_location = 8'h45;
    read_seg(5, 'h45, 1, 0);
    step(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    check("lit_hit_inactive", int'(hit_player), 0);

    // Grow to saturation, then simultaneous grow+shrink
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
    check("lit_len_full", int'(body_length), 8);
    step(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
    check("lit_len_sat", int'(body_length), 8);
    step(1'b0, 8'h00, 2'd0, 1'b1, 1'b1);
    check("lit_len_gs", int'(body_length), 8);
    check("lit_hit_len8", int'(hit_player), 1);
    step(1'b1, 8'h50, 2'd2, 1'b1, 1'b1);

    // Shrink to death
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    check("lit_len_one", int'(body_length), 1);
    check("lit_dead_early", int'(dragon_dead), 0);
    step(1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    check("lit_len_zero", int'(body_length), 0);
    check("lit_dead_set", int'(dragon_dead), 1);
    step(1'b1, 8'h55, 2'd3, 1'b0, 1'b0);
    step(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
    check("lit_dead_len", int'(body_length), 0);
    check("lit_dead_sticky", int'(dragon_dead), 1);
    check("lit_dead_hit", int'(hit_player), 0);
    read_seg(0, 'h50, 2, 0);
    read_seg(1, 'h4A, 1, 0);

    // Asynchronous reset between two moves
    step(1'b1, 8'h60, 2'd1, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check("lit_rst_len", int'(body_length), 3);
    check("lit_rst_dead", int'(dragon_dead), 0);
    check("lit_rst_hit", int'(hit_player), 0);
    read_seg(0, 'h77, 0, 1);
    read_seg(7, 'h77, 0, 0);
    @(posedge frame_clk);
    #1;
    rst = 1'b0;
    step(1'b1, 8'h61, 2'd2, 1'b0, 1'b0);
    read_seg(0, 'h61, 2, 1);
    read_seg(1, 'h77, 0, 1);
    player_location = 8'h61;
    step(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    check("lit_hit_after_rst", int'(hit_player), 1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
